// File: rtl/sequenciador_melodia_if.sv
// Bundle of the melody sequencer's control inputs, note-memory read port and
// note-decoder outputs.
//
// Memory read protocol: the sequencer presents mem_addr and the memory returns
// the matching word on mem_data exactly one clock later.
// There is no valid/ready pair: the sequencer's FETCH state is the wait cycle
// that lines up with that fixed latency.
//
// estado_dbg mirrors the sequencer FSM state so checkers can observe it.
interface sequenciador_melodia_if #(
    parameter int ADDR_W = 4,
    parameter int DUR_W  = 4
);
    logic                iniciar;
    logic                pausar;
    logic                parar;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DUR_W+3:0]    mem_data;
    logic [3:0]          valor;
    logic                enable;
    logic                tocando;
    logic                fim;
    logic [2:0]          estado_dbg;

    modport master (
        input  iniciar, pausar, parar, mem_data,
        output mem_addr, valor, enable, tocando, fim, estado_dbg
    );

    modport slave (
        output iniciar, pausar, parar, mem_data,
        input  mem_addr, valor, enable, tocando, fim, estado_dbg
    );
endinterface

// File: rtl/sequenciador_melodia.sv
// Melody sequencer.
//
// It walks a synchronous note memory, where each word is {valor, dur}, and
// drives a note decoder with valor/enable.
// A note sounds for dur*TICKS_PER_UNIT clocks and is followed by GAP_TICKS
// silent clocks.
// A word with dur==0, or the last address, ends the melody with a one-clock
// fim pulse.
// parar aborts the melody; pausar freezes the timing while it is held.
module sequenciador_melodia #(
    parameter int ADDR_W         = 4,
    parameter int DUR_W          = 4,
    parameter int TICKS_PER_UNIT = 4,
    parameter int GAP_TICKS      = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    sequenciador_melodia_if.master  bus
);

    localparam int TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_FIM   = 3'd5
    } estado_t;

    estado_t              state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [3:0]           valor_q, valor_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 enable_q, enable_d;
    logic                 tocando_q, tocando_d;
    logic                 fim_q, fim_d;
    logic                 advance;

    logic [3:0]           mem_valor;
    logic [DUR_W-1:0]     mem_dur;

    assign mem_valor = bus.mem_data[DUR_W+3:DUR_W];
    assign mem_dur   = bus.mem_data[DUR_W-1:0];

    // Next-state and registered-output logic; parar overrides everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valor_d = valor_q;
        dur_d   = dur_q;
        tick_d  = tick_q;
        gap_d   = gap_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.iniciar) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: begin
                // Address was presented on entry; data arrives next clock.
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (mem_dur == '0) begin
                    state_d = S_FIM;
                end else begin
                    valor_d = mem_valor;
                    dur_d   = mem_dur;
                    tick_d  = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!bus.pausar) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (dur_q == DUR_W'(1)) begin
                            dur_d = '0;
                            if (GAP_TICKS > 0) begin
                                gap_d   = '0;
                                state_d = S_GAP;
                            end else begin
                                advance = 1'b1;
                            end
                        end else begin
                            dur_d = dur_q - DUR_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (!bus.pausar) begin
                    if (gap_q == GAP_LAST) begin
                        advance = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            S_FIM: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Move to the next memory word; the last address ends the melody.
        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                state_d = S_FIM;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end

        if (bus.parar) begin
            state_d = S_IDLE;
            addr_d  = '0;
            dur_d   = '0;
            tick_d  = '0;
            gap_d   = '0;
        end

        // enable follows the PLAY cycle that was counted, so a note sounds
        // for exactly the clocks it spent counting; rests (valor>=12) stay silent.
        enable_d  = (state_q == S_PLAY) && !bus.pausar && !bus.parar && (valor_q <= 4'd11);
        tocando_d = (state_d != S_IDLE);
        fim_d     = (state_d == S_FIM);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            valor_q   <= '0;
            dur_q     <= '0;
            tick_q    <= '0;
            gap_q     <= '0;
            enable_q  <= 1'b0;
            tocando_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            valor_q   <= valor_d;
            dur_q     <= dur_d;
            tick_q    <= tick_d;
            gap_q     <= gap_d;
            enable_q  <= enable_d;
            tocando_q <= tocando_d;
            fim_q     <= fim_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.valor      = valor_q;
    assign bus.enable     = enable_q;
    assign bus.tocando    = tocando_q;
    assign bus.fim        = fim_q;
    assign bus.estado_dbg = state_q;

endmodule

// File: tb/tb_sequenciador_melodia.sv
// Directed bench for sequenciador_melodia.
// Default parameters are used: 4 ticks per unit and 2 gap ticks.
// Sample index 0 is the negedge right after the clock edge that accepts iniciar.
module tb_sequenciador_melodia;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    sequenciador_melodia_if #(.ADDR_W(4), .DUR_W(4)) sif ();

    sequenciador_melodia #(
        .ADDR_W(4), .DUR_W(4), .TICKS_PER_UNIT(4), .GAP_TICKS(2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (sif.master)
    );

    // Synchronous note memory with one clock of read latency.
    logic [7:0] mem [16];
    always @(posedge clock) sif.mem_data <= mem[sif.mem_addr];

    int checks = 0;
    int passed = 0;

    logic       cap_en  [200];
    logic [3:0] cap_val [200];
    logic       cap_fim [200];
    logic       cap_toc [200];
    logic [3:0] cap_addr[200];

    int run_start[32];
    int run_len  [32];
    int run_val  [32];
    int n_runs, fim_cnt, fim_idx, toc_low;

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic start();
        @(negedge clock);
        sif.iniciar = 1'b1;
    endtask

    // Records n cycles of outputs.
    // pausar is held for sample indices in [p0,p1); parar is pulsed at stop_at.
    task automatic capture(input int n, input int p0, input int p1, input int stop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sif.iniciar = 1'b0;
            cap_en[i]   = sif.enable;
            cap_val[i]  = sif.valor;
            cap_fim[i]  = sif.fim;
            cap_toc[i]  = sif.tocando;
            cap_addr[i] = sif.mem_addr;
            sif.pausar  = (i >= p0) && (i < p1);
            sif.parar   = (i == stop_at);
        end
        sif.pausar = 1'b0;
        sif.parar  = 1'b0;
    endtask

    // Reduces a captured trace to enable runs, fim pulses and the tocando drop.
    task automatic analyze(input int n);
        n_runs = 0; fim_cnt = 0; fim_idx = -1; toc_low = -1;
        for (int i = 0; i < n; i++) begin
            if (cap_en[i] && (i == 0 || !cap_en[i-1]) && n_runs < 32) begin
                run_start[n_runs] = i;
                run_len[n_runs]   = 0;
                run_val[n_runs]   = int'(cap_val[i]);
                n_runs++;
            end
            if (cap_en[i] && n_runs > 0) run_len[n_runs-1]++;
            if (cap_fim[i]) begin
                fim_cnt++;
                if (fim_idx < 0) fim_idx = i;
            end
            if (!cap_toc[i] && toc_low < 0) toc_low = i;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sif.iniciar = 1'b0; sif.pausar = 1'b0; sif.parar = 1'b0;
        clear_mem();
        #3;
        checks++;
        if ({sif.mem_addr, sif.valor, sif.enable, sif.tocando, sif.fim} !== 11'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {sif.mem_addr, sif.valor, sif.enable, sif.tocando, sif.fim});
        else passed++;
        checks++;
        if (sif.estado_dbg !== 3'd0) $display("FAIL reset_state: got %0d expected 0", sif.estado_dbg);
        else passed++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic();
        clear_mem();
        mem[0] = {4'd0, 4'd2};
        mem[1] = {4'd11, 4'd1};
        start();
        capture(30, -1, -1, -1);
        analyze(30);
        checks++; if (n_runs !== 2) $display("FAIL basic_runs: got %0d expected 2", n_runs); else passed++;
        checks++; if (run_start[0] !== 3) $display("FAIL basic_latency: got %0d expected 3", run_start[0]); else passed++;
        checks++; if (run_len[0] !== 8) $display("FAIL basic_len0: got %0d expected 8", run_len[0]); else passed++;
        checks++; if (run_val[0] !== 0) $display("FAIL basic_val0: got %0d expected 0", run_val[0]); else passed++;
        checks++; if (run_start[1] !== 15) $display("FAIL basic_start1: got %0d expected 15", run_start[1]); else passed++;
        checks++; if (run_len[1] !== 4) $display("FAIL basic_len1: got %0d expected 4", run_len[1]); else passed++;
        checks++; if (run_val[1] !== 11) $display("FAIL basic_val1: got %0d expected 11", run_val[1]); else passed++;
        checks++; if (fim_cnt !== 1) $display("FAIL basic_fim_cnt: got %0d expected 1", fim_cnt); else passed++;
        checks++; if (fim_idx !== 22) $display("FAIL basic_fim_idx: got %0d expected 22", fim_idx); else passed++;
        checks++; if (toc_low !== 23) $display("FAIL basic_tocando: got %0d expected 23", toc_low); else passed++;
    endtask

    task automatic test_rest();
        clear_mem();
        mem[0] = {4'd13, 4'd1};
        mem[1] = {4'd5, 4'd1};
        start();
        capture(30, -1, -1, -1);
        analyze(30);
        checks++; if (n_runs !== 1) $display("FAIL rest_runs: got %0d expected 1", n_runs); else passed++;
        checks++; if (cap_val[4] !== 4'd13) $display("FAIL rest_valor: got %0d expected 13", cap_val[4]); else passed++;
        checks++; if (run_start[0] !== 11) $display("FAIL rest_start: got %0d expected 11", run_start[0]); else passed++;
        checks++; if (run_len[0] !== 4) $display("FAIL rest_len: got %0d expected 4", run_len[0]); else passed++;
        checks++; if (run_val[0] !== 5) $display("FAIL rest_val: got %0d expected 5", run_val[0]); else passed++;
        checks++; if (fim_idx !== 18) $display("FAIL rest_fim_idx: got %0d expected 18", fim_idx); else passed++;
    endtask

    task automatic test_pause();
        clear_mem();
        mem[0] = {4'd0, 4'd2};
        mem[1] = {4'd11, 4'd1};
        start();
        capture(32, 5, 8, -1);
        analyze(32);
        checks++; if (n_runs !== 3) $display("FAIL pause_runs: got %0d expected 3", n_runs); else passed++;
        checks++; if (run_len[0] + run_len[1] !== 8) $display("FAIL pause_total: got %0d expected 8", run_len[0] + run_len[1]); else passed++;
        checks++; if (run_start[1] !== 9) $display("FAIL pause_resume: got %0d expected 9", run_start[1]); else passed++;
        checks++; if (run_start[2] !== 18) $display("FAIL pause_note2: got %0d expected 18", run_start[2]); else passed++;
        checks++; if (fim_idx !== 25) $display("FAIL pause_fim_idx: got %0d expected 25", fim_idx); else passed++;
    endtask

    task automatic test_pause_fetch();
        clear_mem();
        mem[0] = {4'd0, 4'd2};
        mem[1] = {4'd11, 4'd1};
        start();
        capture(32, 0, 4, -1);
        analyze(32);
        checks++; if (run_start[0] !== 5) $display("FAIL pfetch_start: got %0d expected 5", run_start[0]); else passed++;
        checks++; if (run_len[0] !== 8) $display("FAIL pfetch_len: got %0d expected 8", run_len[0]); else passed++;
        checks++; if (fim_idx !== 24) $display("FAIL pfetch_fim_idx: got %0d expected 24", fim_idx); else passed++;
    endtask

    task automatic test_parar();
        clear_mem();
        mem[0] = {4'd0, 4'd2};
        mem[1] = {4'd11, 4'd1};
        start();
        capture(30, -1, -1, 5);
        analyze(30);
        checks++; if (n_runs !== 1) $display("FAIL parar_runs: got %0d expected 1", n_runs); else passed++;
        checks++; if (run_len[0] !== 3) $display("FAIL parar_len: got %0d expected 3", run_len[0]); else passed++;
        checks++; if (fim_cnt !== 0) $display("FAIL parar_no_fim: got %0d expected 0", fim_cnt); else passed++;
        checks++; if (toc_low !== 6) $display("FAIL parar_tocando: got %0d expected 6", toc_low); else passed++;
        checks++; if (cap_addr[6] !== 4'd0) $display("FAIL parar_addr: got %0d expected 0", cap_addr[6]); else passed++;
        // iniciar and parar together in IDLE: parar wins.
        @(negedge clock);
        sif.iniciar = 1'b1; sif.parar = 1'b1;
        @(negedge clock);
        sif.iniciar = 1'b0; sif.parar = 1'b0;
        checks++; if (sif.tocando !== 1'b0) $display("FAIL parar_wins: got %0d expected 0", sif.tocando); else passed++;
        checks++; if (sif.estado_dbg !== 3'd0) $display("FAIL parar_wins_state: got %0d expected 0", sif.estado_dbg); else passed++;
        // Replay from address 0.
        test_basic();
    endtask

    task automatic test_full_memory();
        for (int i = 0; i < 16; i++) mem[i] = {4'(i % 12), 4'd1};
        start();
        capture(140, -1, -1, -1);
        analyze(140);
        checks++; if (n_runs !== 16) $display("FAIL full_runs: got %0d expected 16", n_runs); else passed++;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (run_start[j] !== 3 + 8 * j || run_len[j] !== 4)
                $display("FAIL full_note%0d: got start %0d len %0d expected start %0d len 4",
                         j, run_start[j], run_len[j], 3 + 8 * j);
            else passed++;
        end
        checks++; if (fim_cnt !== 1) $display("FAIL full_fim_cnt: got %0d expected 1", fim_cnt); else passed++;
        checks++; if (fim_idx !== 128) $display("FAIL full_fim_idx: got %0d expected 128", fim_idx); else passed++;
        checks++; if (cap_addr[128] !== 4'd15) $display("FAIL full_last_addr: got %0d expected 15", cap_addr[128]); else passed++;
        for (int i = 1; i <= 128; i++) begin
            checks++;
            if (cap_addr[i] < cap_addr[i-1])
                $display("FAIL full_no_wrap: idx %0d got %0d expected >= %0d", i, cap_addr[i], cap_addr[i-1]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_play();
        clear_mem();
        mem[0] = {4'd7, 4'd2};
        start();
        capture(6, -1, -1, -1);
        checks++; if (cap_en[5] !== 1'b1 || cap_val[5] !== 4'd7)
            $display("FAIL rmid_before: got en %0d valor %0d expected en 1 valor 7", cap_en[5], cap_val[5]);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({sif.enable, sif.tocando, sif.valor} !== 6'd0)
            $display("FAIL rmid_async: got %h expected 0", {sif.enable, sif.tocando, sif.valor});
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (sif.tocando !== 1'b0 || sif.estado_dbg !== 3'd0)
            $display("FAIL rmid_idle: got tocando %0d state %0d expected 0 0", sif.tocando, sif.estado_dbg);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rest();
        test_pause();
        test_pause_fetch();
        test_parar();
        test_full_memory();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
